// File: rtl/spi_led_ctrl_if.sv
// SPI pin bundle between the Pi header and the LED scheduler.
// The Pi side is the master; the scheduler is the slave.
interface spi_led_ctrl_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (
    output spi_sclk,
    output spi_cs_n,
    output spi_mosi,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs_n,
    input  spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_led_ctrl.sv
// SPI-commanded LED scheduler: off/on/blink/passthrough per LED.
// Define SPI_READBACK_EN to shift a status byte out on MISO.
module spi_led_ctrl #(
  parameter int NUM_LED  = 2,
  parameter int TICK_DIV = 25000
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_led_ctrl_if.slave      spi,
  input  logic [NUM_LED-1:0] pass_in,
  output logic [NUM_LED-1:0] led,
  output logic               cmd_valid,
  output logic               cmd_err
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  logic [2:0]         sclk_q, cs_q;
  logic [1:0]         mosi_q;
  logic [NUM_LED-1:0] pass_q1, pass_q2;

  // cs_q resets low so a frame cut by reset is never seen as started
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= '0;
      cs_q    <= '0;
      mosi_q  <= '0;
      pass_q1 <= '0;
      pass_q2 <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], spi.spi_sclk};
      cs_q    <= {cs_q[1:0], spi.spi_cs_n};
      mosi_q  <= {mosi_q[0], spi.spi_mosi};
      pass_q1 <= pass_in;
      pass_q2 <= pass_q1;
    end
  end

  logic sclk_rise, cs_fall, cs_rise;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];

  logic        active;
  logic [4:0]  bitcnt;
  logic [14:0] shreg;
  logic [1:0]  op;
  logic [3:0]  idx;
  logic [7:0]  data;
  logic        last, idx_ok, short_fr;
  logic        accept, reject;

  assign op       = shreg[14:13];
  assign idx      = shreg[10:7];
  assign data     = {shreg[6:0], mosi_q[1]};
  assign idx_ok   = {1'b0, idx} < 5'(NUM_LED);
  assign last     = sclk_rise & active & ~cs_rise
                  & (bitcnt == 5'd15);
  assign short_fr = cs_rise & active & (bitcnt != 5'd16);
  assign accept   = last & ((op == 2'd2)
                  | ((op != 2'd3) & idx_ok));
  assign reject   = short_fr | (last & ~accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      bitcnt    <= '0;
      shreg     <= '0;
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_valid <= accept;
      cmd_err   <= reject;
      if (cs_fall) begin
        active <= 1'b1;
        bitcnt <= '0;
        shreg  <= '0;
      end else if (cs_rise) begin
        active <= 1'b0;
      end else if (sclk_rise && active && bitcnt != 5'd16) begin
        shreg  <= {shreg[13:0], mosi_q[1]};
        bitcnt <= bitcnt + 5'd1;
      end
    end
  end

  logic [TW-1:0] tcnt;
  logic          tick;
  assign tick = (tcnt == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else        tcnt <= tick ? '0 : tcnt + TW'(1);
  end

  logic                    en;
  logic [NUM_LED-1:0][1:0] mode;
  logic [NUM_LED-1:0][7:0] half, cnt;
  logic [NUM_LED-1:0]      phase;
  logic                    wr_mode, wr_per, wr_en;

  assign wr_mode = accept & (op == 2'd0);
  assign wr_per  = accept & (op == 2'd1);
  assign wr_en   = accept & (op == 2'd2);

  // A command touching an LED's blink state beats a same-cycle tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en    <= 1'b1;
      mode  <= '0;
      half  <= {NUM_LED{8'd250}};
      cnt   <= '0;
      phase <= '0;
    end else begin
      if (wr_en) en <= data[0];
      for (int i = 0; i < NUM_LED; i++) begin
        if (wr_mode && idx == 4'(i)) mode[i] <= data[1:0];
        if (wr_per && idx == 4'(i))
          half[i] <= (data == 8'd0) ? 8'd1 : data;
        if ((wr_mode && idx == 4'(i) && data[1:0] == 2'd2)
            || (wr_per && idx == 4'(i))) begin
          cnt[i]   <= '0;
          phase[i] <= 1'b0;
        end else if (tick && mode[i] == 2'd2) begin
          if (cnt[i] == half[i] - 8'd1) begin
            cnt[i]   <= '0;
            phase[i] <= ~phase[i];
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        unique case (mode[i])
          2'd0: led[i] <= 1'b0;
          2'd1: led[i] <= en;
          2'd2: led[i] <= en & phase[i];
          2'd3: led[i] <= en & pass_q2[i];
        endcase
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic       err_sticky, miso_q;
  logic [5:0] acc_cnt;
  logic [6:0] txsr;

  assign sclk_fall    = ~sclk_q[1] & sclk_q[2];
  assign spi.spi_miso = miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      acc_cnt    <= '0;
      miso_q     <= 1'b0;
      txsr       <= '0;
    end else begin
      if (cmd_err)
        err_sticky <= 1'b1;
      else if (sclk_rise && active && bitcnt == 5'd7)
        err_sticky <= 1'b0;
      if (cmd_valid) acc_cnt <= acc_cnt + 6'd1;
      if (cs_fall) begin
        {miso_q, txsr} <= {en, err_sticky, acc_cnt};
      end else if (cs_rise) begin
        miso_q <= 1'b0;
      end else if (sclk_fall && active) begin
        if (bitcnt < 5'd8) begin
          miso_q <= txsr[6];
          txsr   <= {txsr[5:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
    end
  end
`else
  assign spi.spi_miso = 1'b0;
`endif
endmodule

// File: doc/spi_led_ctrl.md
# spi_led_ctrl

SPI-controlled LED scheduler for the ECP5 board. The Raspberry Pi drives SCLK/CS_N/MOSI on header GPIOs (SCLK via the gp6 bodge) to send 16-bit commands. Each command sets, per LED, one of four modes: off, on, timed blink, or passthrough of a raw input pin. The block sits between the Pi header pins and the board LEDs, replacing direct pin-to-LED wiring.

## Interface
- NUM_LED, 2, number of LEDs controlled (1..16)
- TICK_DIV, 25000, clk cycles per blink tick (1 kHz at 25 MHz)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- spi_sclk  in  1  SPI clock from Pi (asynchronous to clk)
- spi_cs_n  in  1  SPI chip select, active low
- spi_mosi  in  1  SPI data in
- spi_miso  out  1  SPI data out (readback; see Configuration)
- pass_in  in  NUM_LED  raw pins routed to LEDs in passthrough mode
- led  out  NUM_LED  LED drives, active high, registered
- cmd_valid  out  1  one-cycle pulse per accepted command
- cmd_err  out  1  one-cycle pulse per rejected frame

One clock; reset is asynchronous and active-low, ports named clk and rst_n.

## Operation
- spi_sclk, spi_cs_n, spi_mosi and pass_in each pass through a 2-FF synchronizer. A third stage on sclk/cs_n provides edge detection.
- SPI mode 0, MSB first. MOSI is sampled on a detected sclk rising edge while cs_n is low.
- A cs_n falling edge clears the 5-bit bit counter and the shift register.
- Frame format: byte0 = {op[1:0], 2'b00, idx[3:0]}; byte1 = data[7:0].
- On the 16th bit the frame is decoded.
  - Bits after the 16th are ignored until cs_n rises.
  - A cs_n rise with fewer than 16 bits pulses cmd_err and discards the frame.
- Opcodes:
  - op 0 (SET_MODE): mode[idx] = data[1:0]. Encodings: 0 off, 1 on, 2 blink, 3 pass.
  - op 1 (SET_PERIOD): half[idx] = data; data 0 is stored as 1.
  - op 2 (SET_EN): global_en = data[0]; idx is ignored.
  - op 3: reserved, rejected.
- Rejection: op 3, or idx >= NUM_LED for ops 0/1, pulses cmd_err and changes no state.
- Tick generator: a counter 0..TICK_DIV-1 that pulses tick on wrap and free-runs from reset.
- Blink, per LED: an 8-bit cnt and a phase bit, advanced on tick only while mode is blink.
  - When cnt == half-1: toggle phase and clear cnt; otherwise cnt+1.
  - A SET_MODE to blink or any SET_PERIOD to that LED clears cnt and phase.
- Output: led[i] = global_en & (mode off: 0; on: 1; blink: phase; pass: synchronized pass_in[i]).
- Reset values:
  - led = 0, cmd_valid = 0, cmd_err = 0, spi_miso = 0.
  - All modes off, all half = 250, global_en = 1, cnt/phase = 0, tick counter = 0.

## Timing
- Cycle N: 16th sclk rising edge detected (synchronized) and bit shifted in.
- Cycle N+1: cmd_valid or cmd_err high for exactly one cycle; mode/half/en registers updated on the same edge.
- Cycle N+2: led reflects the new state.
- Short frame: cmd_err is high the cycle after the cs_n rise is detected.
- pass_in to led latency: 3 clk cycles.
- SCLK frequency must not exceed clk/8; cs_n high time must be at least 4 clk cycles.
- Simultaneous tick and SET_PERIOD/SET_MODE to the same LED: the command wins, giving cnt = 0 and phase = 0.
- rst_n asserted mid-frame: everything returns to reset values immediately. The partial frame is lost, and no cmd_err is issued for it after reset release.
- A blink with half = H toggles every H ticks, i.e. a period of 2·H·TICK_DIV clk cycles.

## Configuration
- SPI_READBACK_EN defined:
  - During byte0 of each frame, spi_miso shifts out the status byte {global_en, err_sticky, acc_cnt[5:0]}.
  - Bit 7 is driven on the cs_n falling edge; subsequent bits change on detected sclk falling edges.
  - spi_miso is 0 during byte1.
  - err_sticky is set by cmd_err and cleared when a frame completes 8 bits.
  - acc_cnt increments mod 64 per cmd_valid.
- SPI_READBACK_EN undefined:
  - spi_miso is constant 0.
  - No err_sticky or acc_cnt registers are built.

## Test plan
- After reset, send SET_MODE idx0 data 0x01 (0x00,0x01) -> cmd_valid once, led = 2'b01 two cycles later; led1 stays 0.
- SET_PERIOD idx1 data 2, then SET_MODE idx1 data 2, TICK_DIV = 4 -> led[1] toggles every 8 clk cycles starting low; SET_PERIOD data 0 -> toggles every 4 cycles.
- SET_MODE idx0 = 3, drive pass_in[0] 0→1 -> led[0] rises exactly 3 cycles later; SET_EN data 0 -> led = 0 regardless of pass_in.
- Rejected frames: 10-bit frame, op 3, and idx 5 with NUM_LED = 2 -> one cmd_err each, no cmd_valid, led and all registers unchanged.
- rst_n low after bit 9 of a SET_MODE, then a full valid frame -> only the second frame takes effect; no spurious cmd_err.
- With SPI_READBACK_EN: after 3 accepted frames and 1 error, the next frame's MISO byte0 = 0xC3 (en = 1, err = 1, cnt = 3); the frame after reads 0x84 (err cleared, cnt = 4).
